// File: rtl/div_unit_pkg.sv
// ---------------------------------------------------------------------------
// div_unit_pkg
//   Shared constants for the HI/LO divider: FSM state encodings, default
//   register-bus width, stall-request levels and signedness selectors.
// ---------------------------------------------------------------------------
package div_unit_pkg;

    // Default architectural register width
    localparam int REG_BUS = 32;

    // Divider FSM state encodings
    typedef logic [1:0] div_state_t;
    localparam logic [1:0] DIV_IDLE = 2'b00;
    localparam logic [1:0] DIV_ZERO = 2'b01;
    localparam logic [1:0] DIV_BUSY = 2'b10;
    localparam logic [1:0] DIV_DONE = 2'b11;

    // Stall-request levels toward the EX stage
    localparam logic DIV_START = 1'b1;
    localparam logic DIV_STOP  = 1'b0;

    // Operation signedness as presented on signed_i
    localparam logic SIGNED_OP   = 1'b1;
    localparam logic UNSIGNED_OP = 1'b0;

endpackage : div_unit_pkg

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//   Multi-cycle restoring divider producing HI/LO write-backs for DIV/DIVU.
//   One quotient bit per clock; result written as hi = remainder,
//   lo = quotient with a one-cycle strobe.
//
// Ports
//   clk         clock, all state updates on posedge
//   rst         synchronous active-high reset, highest priority
//   start_i     request, sampled only while idle
//   signed_i    1 = DIV (two's complement), 0 = DIVU; captured with start_i
//   dividend_i  dividend, captured with start_i
//   divisor_i   divisor, captured with start_i
//   annul_i     pipeline flush: abandon in-flight op, suppress write-back
//   busy_o      high while an operation is in flight (EX stall request)
//   hilo_we_o   one-cycle write strobe toward HI/LO
//   hi_o        remainder (valid with hilo_we_o, held otherwise)
//   lo_o        quotient  (valid with hilo_we_o, held otherwise)
// ---------------------------------------------------------------------------
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = REG_BUS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             annul_i,
    output logic             busy_o,
    output logic             hilo_we_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t         state_reg,  state_next;
    logic [CNT_W-1:0]   cnt_reg,    cnt_next;
    // {remainder, quotient}. The remainder never reaches the divisor, so its
    // W-bit upper half plus the quotient MSB shifting in form the W+1-bit
    // trial window without needing a separately stored extra bit.
    logic [2*WIDTH-1:0] rq_reg,     rq_next;
    logic [WIDTH-1:0]   dvs_reg,    dvs_next;      // |divisor|
    logic               neg_q_reg,  neg_q_next;    // quotient needs negation
    logic               neg_r_reg,  neg_r_next;    // remainder needs negation
    logic [WIDTH-1:0]   res_hi_reg, res_hi_next;   // staged result for DONE
    logic [WIDTH-1:0]   res_lo_reg, res_lo_next;
    logic [WIDTH-1:0]   hi_reg,     hi_next;       // last committed result
    logic [WIDTH-1:0]   lo_reg,     lo_next;

    logic [WIDTH:0]     trial;
    logic [2*WIDTH-1:0] step_rq;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic               dvd_neg;
    logic               dvs_neg;

    assign dvd_neg = (signed_i == SIGNED_OP) && dividend_i[WIDTH-1];
    assign dvs_neg = (signed_i == SIGNED_OP) && divisor_i[WIDTH-1];

    // One restoring step: shift left, trial-subtract |divisor| from the upper
    // W+1 bits, keep the difference and set the quotient bit when it is
    // non-negative, otherwise keep the shifted value with a 0 quotient bit.
    assign trial   = rq_reg[2*WIDTH-1:WIDTH-1] - {1'b0, dvs_reg};
    assign step_rq = trial[WIDTH] ? {rq_reg[2*WIDTH-2:0], 1'b0}
                                  : {trial[WIDTH-1:0], rq_reg[WIDTH-2:0], 1'b1};
    assign q_mag   = step_rq[WIDTH-1:0];
    assign r_mag   = step_rq[2*WIDTH-1:WIDTH];

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        rq_next     = rq_reg;
        dvs_next    = dvs_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        res_hi_next = res_hi_reg;
        res_lo_next = res_lo_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;

        case (state_reg)
            DIV_IDLE: begin
                if (start_i && !annul_i) begin
                    neg_q_next = dvd_neg ^ dvs_neg;
                    neg_r_next = dvd_neg;
                    dvs_next   = dvs_neg ? -divisor_i : divisor_i;
                    if (divisor_i == '0) begin
                        // Raw dividend parked in the low half becomes the remainder
                        rq_next    = {{WIDTH{1'b0}}, dividend_i};
                        state_next = DIV_ZERO;
                    end else begin
                        rq_next    = {{WIDTH{1'b0}}, (dvd_neg ? -dividend_i : dividend_i)};
                        cnt_next   = '0;
                        state_next = DIV_BUSY;
                    end
                end
            end
            DIV_ZERO: begin
                res_lo_next = '1;
                res_hi_next = rq_reg[WIDTH-1:0];
                state_next  = DIV_DONE;
            end
            DIV_BUSY: begin
                rq_next  = step_rq;
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(WIDTH-1)) begin
                    // Sign fix-up on the final step's result. Most-negative / -1
                    // leaves a magnitude of 2^(W-1) with equal signs, which reads
                    // back as the most-negative pattern: no trap, no special case.
                    res_lo_next = neg_q_reg ? -q_mag : q_mag;
                    res_hi_next = neg_r_reg ? -r_mag : r_mag;
                    state_next  = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (!annul_i) begin
                    hi_next = res_hi_reg;
                    lo_next = res_lo_reg;
                end
                state_next = DIV_IDLE;
            end
            default: state_next = DIV_IDLE;
        endcase

        // A flush abandons whatever is in flight
        if (annul_i && (state_reg != DIV_IDLE)) begin
            state_next = DIV_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= DIV_IDLE;
            cnt_reg    <= '0;
            rq_reg     <= '0;
            dvs_reg    <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            res_hi_reg <= '0;
            res_lo_reg <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            rq_reg     <= rq_next;
            dvs_reg    <= dvs_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            res_hi_reg <= res_hi_next;
            res_lo_reg <= res_lo_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
        end
    end

    // The strobe must drop in the same cycle a flush arrives, so annul_i gates
    // the registered DONE state; hi/lo present the staged result only while
    // the strobe is high and the committed value otherwise.
    assign busy_o    = (state_reg != DIV_IDLE) ? DIV_START : DIV_STOP;
    assign hilo_we_o = (state_reg == DIV_DONE) && !annul_i;
    assign hi_o      = hilo_we_o ? res_hi_reg : hi_reg;
    assign lo_o      = hilo_we_o ? res_lo_reg : lo_reg;

endmodule : div_unit

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit
//   Self-checking bench for div_unit: a cycle-count behavioural model using
//   plain integer division, a per-cycle compare process, and directed
//   scenarios with hand-computed literal results.
// ---------------------------------------------------------------------------
module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic         signed_i;
    logic [W-1:0] dividend_i;
    logic [W-1:0] divisor_i;
    logic         annul_i;
    logic         busy_o;
    logic         hilo_we_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;
    bit chk_en  = 0;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .annul_i    (annul_i),
        .busy_o     (busy_o),
        .hilo_we_o  (hilo_we_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    // Reference result {remainder, quotient} from integer arithmetic
    function automatic logic [63:0] ref_div(bit s, logic [31:0] a, logic [31:0] b);
        longint x, y, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'({32'd0, a});
            y = longint'({32'd0, b});
        end
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    // Behavioural model: m_left = cycles remaining up to and including the
    // write-back cycle; 0 means idle.
    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
        end else if (m_left > 0) begin
            if (annul_i) m_left = 0;
            else begin
                if (m_left == 1) begin
                    m_hi = m_rhi;
                    m_lo = m_rlo;
                end
                m_left--;
            end
        end else if (start_i && !annul_i) begin
            {m_rhi, m_rlo} = ref_div(signed_i, dividend_i, divisor_i);
            m_left = (divisor_i == '0) ? 2 : W + 1;
        end
    end

    // Per-cycle comparison against the model
    bit prev_we = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_we;
            exp_we = (m_left == 1) && !annul_i;
            check("busy", {31'd0, busy_o}, {31'd0, (m_left > 0)});
            check("hilo_we", {31'd0, hilo_we_o}, {31'd0, exp_we});
            check("hi", hi_o, exp_we ? m_rhi : m_hi);
            check("lo", lo_o, exp_we ? m_rlo : m_lo);
            if (hilo_we_o) check("we_back_to_back", {31'd0, prev_we}, 32'd0);
            prev_we = hilo_we_o;
        end
    end

    task automatic start_op(bit s, logic [31:0] a, logic [31:0] b);
        @(posedge clk); #1;
        start_i = 1'b1; signed_i = s; dividend_i = a; divisor_i = b;
        @(posedge clk); #1;
        start_i = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_write(string name, int exp_lat, logic [31:0] el, logic [31:0] eh);
        bit found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clk);
            if (hilo_we_o === 1'b1) begin
                found = 1'b1;
                check({name, "_latency"}, cyc - t0 + 1, exp_lat);
                check({name, "_lo"}, lo_o, el);
                check({name, "_hi"}, hi_o, eh);
                $display("[TB] %s: lo=%h hi=%h latency=%0d", name, lo_o, hi_o, cyc - t0 + 1);
            end
        end
        if (!found) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no hilo_we_o expected a write-back", name);
        end
        @(posedge clk); #1;
    endtask

    task automatic run(string name, bit s, logic [31:0] a, logic [31:0] b,
                       int lat, logic [31:0] el, logic [31:0] eh);
        start_op(s, a, b);
        wait_write(name, lat, el, eh);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
        dividend_i = '0; divisor_i = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        check("reset_we", {31'd0, hilo_we_o}, 32'd0);
        check("reset_hi", hi_o, 32'd0);
        check("reset_lo", lo_o, 32'd0);
        $display("[TB] reset: busy=%b we=%b hi=%h lo=%h", busy_o, hilo_we_o, hi_o, lo_o);

        // DIVU 100/7
        run("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 32'h0000_000E, 32'h0000_0002);
        @(negedge clk);
        check("divu_100_7_busy_after", {31'd0, busy_o}, 32'd0);

        // Annul mid-division at cycle 10
        start_op(1'b0, 32'd100, 32'd7);
        repeat (9) @(posedge clk);
        #1 annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        @(negedge clk);
        check("annul_busy", {31'd0, busy_o}, 32'd0);
        check("annul_hi_kept", hi_o, 32'h0000_0002);
        check("annul_lo_kept", lo_o, 32'h0000_000E);
        $display("[TB] annul at cycle 10: busy=%b hi=%h lo=%h", busy_o, hi_o, lo_o);
        run("restart_100_7", 1'b0, 32'd100, 32'd7, 33, 32'h0000_000E, 32'h0000_0002);

        // Start pulses during BUSY are ignored
        start_op(1'b0, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1 start_i = 1'b1; dividend_i = 32'd9; divisor_i = 32'd3;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        wait_write("ignored_start", 33, 32'h0000_000E, 32'h0000_0002);

        // Signed operations
        run("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run("div_minneg_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'h0);
        run("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'h1);
        run("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        run("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'h0);
        run("divu_3_max", 1'b0, 32'd3, 32'hFFFF_FFFF, 33, 32'h0, 32'h3);

        // Divide by zero
        run("divu_5_0", 1'b0, 32'd5, 32'd0, 2, 32'hFFFF_FFFF, 32'h0000_0005);
        run("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

        // Annul during the DONE cycle suppresses the write-back
        start_op(1'b0, 32'd100, 32'd7);
        repeat (32) @(posedge clk);
        #1 annul_i = 1'b1;
        @(negedge clk);
        check("annul_done_we", {31'd0, hilo_we_o}, 32'd0);
        check("annul_done_hi", hi_o, 32'hFFFF_FFFB);
        check("annul_done_lo", lo_o, 32'hFFFF_FFFF);
        @(posedge clk); #1 annul_i = 1'b0;
        @(negedge clk);
        check("annul_done_busy", {31'd0, busy_o}, 32'd0);
        $display("[TB] annul in DONE: busy=%b hi=%h lo=%h", busy_o, hi_o, lo_o);

        // Start together with annul in IDLE is ignored
        @(posedge clk); #1;
        start_i = 1'b1; annul_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd50; divisor_i = 32'd5;
        @(posedge clk); #1;
        start_i = 1'b0; annul_i = 1'b0;
        @(negedge clk);
        check("start_annul_busy", {31'd0, busy_o}, 32'd0);
        $display("[TB] start+annul in IDLE: busy=%b", busy_o);
        repeat (40) @(posedge clk);
        #1;

        // Reset mid-division at cycle 20
        start_op(1'b0, 32'd100, 32'd7);
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
        check("rst_mid_we", {31'd0, hilo_we_o}, 32'd0);
        check("rst_mid_hi", hi_o, 32'd0);
        check("rst_mid_lo", lo_o, 32'd0);
        $display("[TB] reset mid-division: busy=%b we=%b hi=%h lo=%h", busy_o, hilo_we_o, hi_o, lo_o);
        repeat (40) @(posedge clk);
        #1;

        run("divu_1000_10", 1'b0, 32'd1000, 32'd10, 33, 32'h0000_0064, 32'h0);
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_div_unit
